mux_scan_seq: RTL

- Parametrised N-channel, W-bit registered multiplexer. Generalises the gate-level 4:1 mux.
- Adds two modes: manual select, and an auto-scan sequencer. The sequencer cycles through enabled channels, dwells a programmable number of cycles on each, and reports which channel is on the output.
- Sits between multi-channel sources and a single-lane consumer: time-division sampling, or debug observation of several buses.

---
 rtl/mux_scan_pkg.sv | 28 ++
 rtl/mux_next_sel.sv | 37 +++
 rtl/mux_scan_seq.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux_scan_seq block: auto-scan FSM state encoding,
// mode constants and small constant-function helpers for derived widths.
package mux_scan_pkg;

    // Auto-scan FSM state, kept as plain constants for legacy tool compatibility.
    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t SCAN = 1'b1;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

    // Clamp a derived width to at least one bit.
    function automatic int unsigned max1(input int unsigned value);
        return (value < 1) ? 1 : value;
    endfunction

endpackage

// File: rtl/mux_next_sel.sv
// Circular priority finder: returns the first set mask bit strictly after
// idx_i, searching idx_i+1, idx_i+2, ... modulo CHANNELS (idx_i itself is
// checked last). Passing idx_i = CHANNELS-1 yields the lowest set bit.
//   mask_i    : channel enable mask
//   idx_i     : current channel index
//   next_o    : next enabled index (idx_i when nothing is found)
//   found_o   : at least one mask bit is set
//   wrapped_o : next index is lower than or equal to idx_i
module mux_next_sel #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SELW     = 2
) (
    input  logic [CHANNELS-1:0] mask_i,
    input  logic [SELW-1:0]     idx_i,
    output logic [SELW-1:0]     next_o,
    output logic                found_o,
    output logic                wrapped_o
);

    logic [SELW-1:0] cand;

    always_comb begin
        next_o  = idx_i;
        found_o = 1'b0;
        cand    = '0;
        // Walk farthest-first so the nearest hit is the last assignment.
        for (int k = CHANNELS; k >= 1; k--) begin
            cand = SELW'((int'(idx_i) + k) % CHANNELS);
            if (mask_i[cand]) begin
                next_o  = cand;
                found_o = 1'b1;
            end
        end
        wrapped_o = found_o && (next_o <= idx_i);
    end

endmodule

// File: rtl/mux_scan_seq.sv
// N-channel, W-bit registered multiplexer with manual select and an auto-scan
// sequencer that dwells DWELL enabled cycles on each enabled channel.
//   clk_i        : clock, all state on rising edge
//   rst_i        : synchronous active-high reset
//   en_i         : advance/sample enable
//   mode_i       : 0 = manual (sel_i), 1 = auto scan
//   sel_i        : manual channel select
//   ch_mask_i    : auto-scan channel enables
//   din_i        : packed channel data, channel i at [i*WIDTH +: WIDTH]
//   dout_o       : registered selected data
//   dout_valid_o : dout_o/dout_ch_o hold a legal sample
//   dout_ch_o    : channel index of dout_o
//   wrap_o       : one-cycle pulse when the auto pointer wraps
module mux_scan_seq
    import mux_scan_pkg::*;
#(
    parameter int unsigned  WIDTH    = 1,
    parameter int unsigned  CHANNELS = 4,
    parameter int unsigned  DWELL    = 1,
    localparam int unsigned SELW     = max1(clog2(CHANNELS)),
    localparam int unsigned DCW      = max1(clog2(DWELL))
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic                      mode_i,
    input  logic [SELW-1:0]           sel_i,
    input  logic [CHANNELS-1:0]       ch_mask_i,
    input  logic [CHANNELS*WIDTH-1:0] din_i,
    output logic [WIDTH-1:0]          dout_o,
    output logic                      dout_valid_o,
    output logic [SELW-1:0]           dout_ch_o,
    output logic                      wrap_o
);

    logic [WIDTH-1:0] ch_data [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
        assign ch_data[i] = din_i[i*WIDTH +: WIDTH];
    end

    state_t           state_q, state_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [DCW-1:0]   dcnt_q, dcnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic [SELW-1:0]  ch_q, ch_d;
    logic             wrap_q, wrap_d;

    // One finder serves both searches: from CHANNELS-1 in IDLE (lowest set
    // bit) and from the current pointer in SCAN.
    logic [SELW-1:0] search_idx, next_idx;
    logic            next_found, next_wrapped;

    assign search_idx = (state_q == SCAN) ? ptr_q : SELW'(CHANNELS - 1);

    mux_next_sel #(
        .CHANNELS (CHANNELS),
        .SELW     (SELW)
    ) u_next_sel (
        .mask_i    (ch_mask_i),
        .idx_i     (search_idx),
        .next_o    (next_idx),
        .found_o   (next_found),
        .wrapped_o (next_wrapped)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        dcnt_d  = dcnt_q;
        dout_d  = dout_q;
        ch_d    = ch_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;

        if (mode_i == MODE_MANUAL) begin
            // Leaving auto mode always restarts the scan from IDLE.
            state_d = IDLE;
        end

        if (!en_i) begin
            // Hold data and pointer; valid/wrap already cleared.
        end else if (mode_i == MODE_MANUAL) begin
            ch_d = sel_i;
            if (int'(sel_i) < CHANNELS) begin
                dout_d  = ch_data[sel_i];
                valid_d = 1'b1;
            end else begin
                dout_d = '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (next_found) begin
                        ptr_d   = next_idx;
                        dcnt_d  = '0;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    if (ch_mask_i == '0) begin
                        state_d = IDLE;
                    end else if (!ch_mask_i[ptr_q]) begin
                        // Current channel disabled mid-dwell: skip without sampling.
                        ptr_d  = next_idx;
                        dcnt_d = '0;
                        wrap_d = next_wrapped;
                    end else begin
                        dout_d  = ch_data[ptr_q];
                        ch_d    = ptr_q;
                        valid_d = 1'b1;
                        if (dcnt_q == DCW'(DWELL - 1)) begin
                            dcnt_d = '0;
                            ptr_d  = next_idx;
                            wrap_d = next_wrapped;
                        end else begin
                            dcnt_d = dcnt_q + DCW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            dcnt_q  <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dcnt_q  <= dcnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ch_q    <= ch_d;
            wrap_q  <= wrap_d;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;
    assign dout_ch_o    = ch_q;
    assign wrap_o       = wrap_q;

endmodule
